// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, Rcon constants, round/word types and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_NR     = 10;
  localparam int unsigned AES_KEY_W  = 128;
  localparam int unsigned AES_WORD_W = 32;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef logic [3:0]            round_t;
  typedef logic [AES_WORD_W-1:0] word_t;

  typedef enum logic {EMPTY, READY} ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // Inverse computed as data^254 (maps 0 to 0 as required).
  assign x2   = gf_mul(data, data);
  assign x3   = gf_mul(x2, data);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign inv  = gf_mul(gf_mul(x240, x12), x2);

  assign sub = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// On-the-fly AES-128 key expansion: holds one round key plus Rcon and steps on advance.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned KEY_W      = AES_KEY_W,
  parameter int unsigned LAST_ROUND = AES_NR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             advance,
  input  logic [3:0]       round_chk,
  input  logic             clr_err,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       key_round,
  output logic             key_valid,
  output logic             last_key,
  output logic             sync_err
);

  localparam round_t LAST = round_t'(LAST_ROUND);

  ks_state_t  state;
  logic [7:0] rcon;
  word_t      w0, w1, w2, w3, sub_rot, temp, n0, n1, n2, n3;
  round_t     next_round;
  logic       at_last, err_set;

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  // SubWord(RotWord(w3)): byte lanes already rotated at the S-box inputs.
  aes_sbox u_sbox0 (.data(w3[23:16]), .sub(sub_rot[31:24]));
  aes_sbox u_sbox1 (.data(w3[15:8]),  .sub(sub_rot[23:16]));
  aes_sbox u_sbox2 (.data(w3[7:0]),   .sub(sub_rot[15:8]));
  aes_sbox u_sbox3 (.data(w3[31:24]), .sub(sub_rot[7:0]));

  assign temp = sub_rot ^ {rcon, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  assign next_round = key_round + 4'd1;
  assign at_last    = (key_round == LAST);
  assign key_valid  = (state == READY);

  // The final-round strobe from the controller is expected and must not flag drift.
  assign err_set = advance && !load &&
                   ((state == EMPTY) ||
                    ((round_chk != key_round) && !(at_last && (round_chk == LAST))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      round_key <= '0;
      key_round <= '0;
      rcon      <= RCON_INIT;
      last_key  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (load) begin
        state     <= READY;
        round_key <= key_in;
        key_round <= '0;
        rcon      <= RCON_INIT;
        last_key  <= 1'b0;
      end else if (advance && (state == READY) && !at_last) begin
        round_key <= {n0, n1, n2, n3};
        key_round <= next_round;
        rcon      <= xtime(rcon);
        last_key  <= (next_round == LAST);
      end

      if (err_set)      sync_err <= 1'b1;
      else if (clr_err) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a full-expansion reference model.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [127:0] key_in = '0;
  logic         advance = 1'b0;
  logic [3:0]   round_chk = '0;
  logic         clr_err = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   key_round;
  logic         key_valid;
  logic         last_key;
  logic         sync_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  aes_key_schedule #(.KEY_W(128), .LAST_ROUND(10)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .key_in(key_in), .advance(advance),
    .round_chk(round_chk), .clr_err(clr_err), .round_key(round_key),
    .key_round(key_round), .key_valid(key_valid), .last_key(last_key), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] rcon_tab [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  // Classic 44-word expansion; returns round key r.
  function automatic logic [127:0] expand(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rcon_tab[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  logic [127:0] m_key = '0;
  int           m_round = 0;
  bit           m_valid = 0;
  bit           m_err = 0;

  task automatic model_reset();
    m_round = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step(input bit ld, input logic [127:0] k, input bit adv,
                            input int chk, input bit clr);
    bit set;
    set = adv && !ld && (!m_valid || (chk != m_round && !(m_round == 10 && chk == 10)));
    if (ld) begin
      m_key = k; m_round = 0; m_valid = 1;
    end else if (adv && m_valid && m_round < 10) begin
      m_round++;
    end
    if (set) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".round_key"}, round_key, m_valid ? expand(m_key, m_round) : 128'h0);
    check({tag, ".key_round"}, 128'(key_round), 128'(m_round));
    check({tag, ".key_valid"}, 128'(key_valid), 128'(m_valid));
    check({tag, ".last_key"},  128'(last_key),  128'(m_valid && m_round == 10));
    check({tag, ".sync_err"},  128'(sync_err),  128'(m_err));
  endtask

  task automatic tick(input bit ld, input logic [127:0] k, input bit adv,
                      input int chk, input bit clr);
    load = ld; key_in = k; advance = adv; round_chk = 4'(chk); clr_err = clr;
    @(posedge clk);
    model_step(ld, k, adv, chk, clr);
    #1;
    load = 1'b0; advance = 1'b0; clr_err = 1'b0;
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    logic [127:0] rk;
    bit ld, adv, clr;
    int chk;

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    tick(1, FIPS_KEY, 0, 0, 0);
    check_all("load");
    check("load.fips", round_key, FIPS_KEY);

    for (int r = 0; r < 10; r++) begin
      tick(0, '0, 1, r, 0);
      check_all($sformatf("adv%0d", r + 1));
      if (r == 0) check("fips.k1", round_key, FIPS_K1);
    end
    check("fips.k10", round_key, FIPS_K10);
    check("fips.k10.last", 128'(last_key), 128'd1);
    rk = round_key;

    tick(0, '0, 1, 10, 0);
    check_all("extra_adv");
    check("extra_adv.hold", round_key, rk);

    tick(1, 128'h000102030405060708090a0b0c0d0e0f, 0, 0, 0);
    for (int r = 0; r < 3; r++) tick(0, '0, 1, r, 0);
    tick(0, '0, 1, 5, 0);
    check_all("drift");
    check("drift.round", 128'(key_round), 128'd4);
    tick(0, '0, 0, 0, 0);
    check_all("drift.sticky");
    tick(0, '0, 0, 0, 1);
    check_all("clr");
    tick(0, '0, 1, 0, 1);
    check_all("set_wins");
    tick(0, '0, 0, 0, 1);

    tick(0, '0, 1, 5, 0);
    check_all("to_round6");
    tick(1, FIPS_KEY, 1, 6, 0);
    check_all("load_adv");
    tick(0, '0, 1, 0, 0);
    check_all("restart_k1");
    check("restart.fips_k1", round_key, FIPS_K1);

    for (int r = 1; r < 4; r++) tick(0, '0, 1, r, 0);
    check("pre_reset.round", 128'(key_round), 128'd4);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    #1 rst_n = 1'b1;
    @(negedge clk);
    tick(0, '0, 1, 0, 0);
    check_all("adv_empty");
    tick(0, '0, 0, 0, 1);

    for (int n = 0; n < 300; n++) begin
      ld  = ($urandom_range(15) == 0);
      adv = ($urandom_range(1) == 1);
      clr = ($urandom_range(7) == 0);
      chk = ($urandom_range(7) == 0) ? int'($urandom_range(15)) : m_round;
      tick(ld, {$urandom, $urandom, $urandom, $urandom}, adv, chk, clr);
      check_all($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- On-the-fly AES-128 key expansion stage. It feeds the round datapath one 128-bit round key per round, stepped in lockstep with the round controller.
- Holds only the current round key and Rcon, with no 11-entry key RAM. It advances on the controller's state-enable strobe.
- Flags any drift between its internal round index and the controller's round counter.

Parameters:
- KEY_W, 128, key/round-key width; only 128 is supported (AES-128, 10 rounds).
- LAST_ROUND, 10, index of the final round key; advancing saturates here.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- load  in  1  capture key_in as round key 0; pulse while the controller is IDLE with start asserted
- key_in  in  128  cipher key; word w0 = key_in[127:96]
- advance  in  1  step to the next round key; tie to the controller's state_en
- round_chk  in  4  controller round counter, used for the sync check
- clr_err  in  1  synchronous clear of sync_err
- round_key  out  128  current round key, registered
- key_round  out  4  index (0..10) of round_key
- key_valid  out  1  round_key holds a key from a completed load
- last_key  out  1  key_round == LAST_ROUND
- sync_err  out  1  sticky: an advance occurred while round_chk != key_round

Behaviour:
- Reset state:
  - round_key = 0, key_round = 0, key_valid = 0, last_key = 0, sync_err = 0.
  - Internal rcon = 8'h01.
- Load, at the clock edge with load = 1:
  - round_key <= key_in, key_round <= 0, rcon <= 8'h01.
  - key_valid <= 1, last_key <= 0.
  - Load has priority over a simultaneous advance. sync_err is not affected.
- Advance, at the clock edge with advance = 1, load = 0, key_valid = 1 and key_round < LAST_ROUND:
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - round_key <= {w0', w1', w2', w3'}; key_round <= key_round + 1.
  - rcon <= xtime(rcon), i.e. {rcon[6:0], 0} ^ (rcon[7] ? 8'h1b : 0).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Advance when key_round == LAST_ROUND is ignored: the key holds, key_round stays 10, no error. This absorbs the controller's final-round strobe.
- Advance while key_valid = 0 is ignored and sets sync_err.
- last_key is registered and equals (key_round == LAST_ROUND) after each update.
- Latency: one cycle from an advance edge to the new round_key. Keys are consumed as follows:
  - The INIT cycle uses key 0.
  - Round r (round_chk = r) sees key r, since INIT's advance produces key 1.
- Sync check: at an advance edge with load = 0, if round_chk != key_round then sync_err <= 1.
  - Suppressed when key_round == LAST_ROUND and round_chk == LAST_ROUND.
  - clr_err clears sync_err. A simultaneous set wins over clr_err.
- A load in the middle of an expansion restarts from key 0 immediately. The partial key is discarded.
- Async reset mid-expansion returns all outputs to their reset values. key_valid = 0 until the next load.
- Two logical states:
  - EMPTY: key_valid = 0.
  - READY: key_valid = 1, with key_round as the sub-state.
  - EMPTY -> READY on load. Only reset returns to EMPTY.

Decomposition:
- Shared package aes_pkg:
  - AES_NR = 10, AES_KEY_W = 128, AES_WORD_W = 32.
  - RCON_INIT = 8'h01, XTIME_POLY = 8'h1b.
  - Round-index typedef (4 bits) and word typedef (32 bits).
- One sub-module: aes_sbox, a combinational 8-bit forward S-box shared with the datapath. Instantiate four copies for SubWord.

Test Plan:
- Reset, then load key 2b7e151628aed2a6abf7158809cf4f3c.
  - Next cycle: round_key = that key, key_round = 0, key_valid = 1.
- From the loaded key, assert advance with round_chk tracking 0..9:
  - After the 1st advance, round_key = a0fafe1788542cb123a339392a6c7605.
  - After the 10th advance, round_key = d014f9a8c9ee2589e13f0cc8b6630ca6, key_round = 10, last_key = 1, sync_err = 0.
- Extra advance at key_round = 10 with round_chk = 10:
  - round_key is unchanged, key_round = 10, sync_err = 0.
- Advance with round_chk = 5 while key_round = 3:
  - sync_err = 1 and stays set until clr_err.
  - Key still advances to key_round = 4.
- load and advance together at key_round = 6:
  - key_round = 0, round_key = key_in, rcon restarts; the next advance yields the round-1 key again.
- Drop rst_n at key_round = 4:
  - All outputs read 0 immediately (async).
  - advance before any load is ignored and sets sync_err.
